// File: rtl/nibble_mem_responder.sv
// nibble_mem_responder: memory-side end of the 4-bit nibble-serial bus, backed by a word-wide RAM port.
// Latency: read mem_ready N+3 cycles after accept (N = 2/4/8 nibbles); write mem_ready 2 cycles after last nibble.
// Backpressure: req_ready only in IDLE; write nibbles may stall indefinitely, read nibbles stream without stall.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   req_valid/req_ready         request handshake; req_write, req_type, req_addr describe the access
//   nib_in/nib_in_valid         write nibble stream from the controller
//   nib_out/nib_out_valid       read nibble stream to the controller; nib_pos = slot code of current nibble
//   mem_ready/mem_err           one-cycle completion / reject pulses
//   bk_*                        word-wide backing RAM port (read data valid the cycle after bk_rd)

module nibble_mem_responder #(
  parameter logic [23:0] ADDR_LIMIT = 24'hFF_FFFF,
  parameter int          BK_AW      = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_type,
  input  logic [23:0]      req_addr,
  input  logic [3:0]       nib_in,
  input  logic             nib_in_valid,
  output logic [3:0]       nib_out,
  output logic             nib_out_valid,
  output logic [2:0]       nib_pos,
  output logic             mem_ready,
  output logic             mem_err,
  output logic [BK_AW-1:0] bk_addr,
  output logic             bk_rd,
  output logic             bk_wr,
  output logic [3:0]       bk_be,
  output logic [31:0]      bk_wdata,
  input  logic [31:0]      bk_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_SEND,
    S_WR_COLLECT,
    S_WR_COMMIT,
    S_DONE
  } state_t;

  state_t      state, next_state;

  // The read/write direction is carried by the state path itself (RD_* vs WR_*),
  // so only address and size need to be held for the rest of the access.
  logic [23:0] addr_q;
  logic [1:0]  type_q;
  logic [31:0] data_q;   // read: shift register; write: collected nibbles
  logic [2:0]  cnt;      // nibble index k

  logic        req_bad;
  logic [2:0]  last_k;
  logic [31:0] rd_mask;
  logic [3:0]  be;
  logic [2:0]  slot;

  // Zero-extend both sides so the limit compare stays meaningful for any ADDR_LIMIT.
  assign req_bad = (req_type == 2'b00)
                || ({1'b0, req_addr} > {1'b0, ADDR_LIMIT})
                || ((req_type == 2'b10) && req_addr[0])
                || ((req_type == 2'b11) && (req_addr[1:0] != 2'b00));

  // Slot code interleaves the low index bit to the top: 000,100,001,101,...
  assign slot = {cnt[0], cnt[2:1]};

  always_comb begin
    last_k  = 3'd7;
    rd_mask = 32'hFFFF_FFFF;
    be      = 4'b1111;
    case (type_q)
      2'b01: begin
        last_k  = 3'd1;
        rd_mask = 32'h0000_00FF;
        be      = 4'b0001 << addr_q[1:0];
      end
      2'b10: begin
        last_k  = 3'd3;
        rd_mask = 32'h0000_FFFF;
        be      = 4'b0011 << addr_q[1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    req_ready     = 1'b0;
    nib_out       = 4'h0;
    nib_out_valid = 1'b0;
    nib_pos       = 3'b000;
    mem_ready     = 1'b0;
    mem_err       = 1'b0;
    bk_addr       = '0;
    bk_rd         = 1'b0;
    bk_wr         = 1'b0;
    bk_be         = 4'b0000;
    bk_wdata      = 32'h0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)        next_state = S_ERR;
          else if (req_write) next_state = S_WR_COLLECT;
          else                next_state = S_RD_REQ;
        end
      end
      S_ERR: begin
        mem_err    = 1'b1;
        next_state = S_IDLE;
      end
      S_RD_REQ: begin
        bk_rd      = 1'b1;
        bk_addr    = addr_q[BK_AW+1:2];
        next_state = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        next_state = S_RD_SEND;
      end
      S_RD_SEND: begin
        nib_out_valid = 1'b1;
        nib_out       = data_q[3:0];
        nib_pos       = slot;
        if (cnt == last_k) next_state = S_DONE;
      end
      S_WR_COLLECT: begin
        nib_pos = slot;
        if (nib_in_valid && (cnt == last_k)) next_state = S_WR_COMMIT;
      end
      S_WR_COMMIT: begin
        bk_wr      = 1'b1;
        bk_addr    = addr_q[BK_AW+1:2];
        bk_be      = be;
        bk_wdata   = data_q << {addr_q[1:0], 3'b000};
        next_state = S_DONE;
      end
      S_DONE: begin
        mem_ready  = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= 24'h0;
      type_q <= 2'b00;
      data_q <= 32'h0;
      cnt    <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            type_q <= req_type;
            data_q <= 32'h0;
            cnt    <= 3'd0;
          end
        end
        S_RD_WAIT: begin
          // Align the addressed byte lane to bit 0 and drop unrequested bytes.
          data_q <= (bk_rdata >> {addr_q[1:0], 3'b000}) & rd_mask;
        end
        S_RD_SEND: begin
          data_q <= data_q >> 4;
          cnt    <= cnt + 3'd1;
        end
        S_WR_COLLECT: begin
          if (nib_in_valid) begin
            data_q[{cnt, 2'b00} +: 4] <= nib_in;
            cnt                       <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/nibble_mem_responder.md
Name: nibble_mem_responder

Overview:
- Memory-side responder for the 4-bit nibble-serial memory bus.
- Accepts a request (24-bit byte address, access size, read/write) from the core memory controller.
- On a read, fetches one word from a word-wide backing RAM port and returns the addressed bytes as a nibble stream. On a write, collects the nibble stream and commits it with byte enables.
- Signals completion with a one-cycle ready pulse. Misaligned or out-of-range requests get a one-cycle error pulse.

Parameters:
- ADDR_LIMIT, 24'hFF_FFFF: highest legal byte address; any request address above it is rejected.
- BK_AW, 22: backing RAM word-address width. bk_addr = req_addr[BK_AW+1:2].

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_type  in  2  01 = byte, 10 = halfword, 11 = word, 00 = illegal
- req_addr  in  24  byte address
- nib_in  in  4  write nibble from controller
- nib_in_valid  in  1  nib_in valid this cycle
- nib_out  out  4  read nibble to controller
- nib_out_valid  out  1  nib_out valid this cycle
- nib_pos  out  3  slot code of the current or expected nibble
- mem_ready  out  1  one-cycle completion pulse
- mem_err  out  1  one-cycle reject pulse
- bk_addr  out  BK_AW  backing word address
- bk_rd  out  1  backing read strobe; data valid the following cycle
- bk_wr  out  1  backing write strobe
- bk_be  out  4  backing byte enables
- bk_wdata  out  32  backing write data, lane-aligned
- bk_rdata  in  32  backing read data, valid the cycle after bk_rd

Behaviour:
- Reset values:
  - All outputs 0 except req_ready = 1.
  - State = IDLE; shift register, nibble counter and latched request are cleared.
- Reset mid-operation: abort immediately. No bk_wr is issued afterwards and no mem_ready or mem_err pulse is produced.
- Nibble count N: byte = 2, half = 4, word = 8.
- Nibble k (k = 0..N-1) carries data bits [4k+3:4k], least significant nibble first.
- nib_pos = {k[0], k[2:1]}, giving the sequence 000, 100, 001, 101, 010, 110, 011, 111.
- Request acceptance (in IDLE):
  - Latch addr, type and write.
  - Error condition: type 00, or addr > ADDR_LIMIT, or half with addr[0] = 1, or word with addr[1:0] != 00.
  - On error, go to ERR. Otherwise go to RD_REQ (read) or WR_COLLECT (write).
- States:
  - ERR: mem_err = 1 for one cycle; no backing access; then IDLE.
  - RD_REQ: bk_rd = 1 and bk_addr driven, for one cycle; then RD_WAIT.
  - RD_WAIT: capture bk_rdata >> (8*addr[1:0]) into the shift register, masked to 8*N bits; then RD_SEND.
  - RD_SEND: one nibble per cycle with nib_out_valid = 1 and nib_pos = slot k, for exactly N cycles with no stall; then DONE.
  - WR_COLLECT:
    - nib_pos shows the expected slot.
    - Each cycle with nib_in_valid = 1 stores nib_in at slot k and increments k.
    - Cycles without nib_in_valid wait indefinitely.
    - After the N-th nibble, go to WR_COMMIT.
  - WR_COMMIT: one cycle with bk_wr = 1 and:
    - bk_wdata = collected << (8*addr[1:0]);
    - bk_be: byte = 0001 << addr[1:0], half = 0011 << addr[1:0], word = 1111.
    - Then DONE.
  - DONE: mem_ready = 1 for one cycle; then IDLE.
- Latency from the accept edge: read mem_ready at cycle N+3; write mem_ready at cycle W+2, where W is the cycle the last nibble arrives.
- nib_in_valid outside WR_COLLECT is ignored.
- req_valid while busy is ignored; the controller must hold it until req_ready is high.
- bk_rd and bk_wr are never both high in the same cycle.
- nib_out is 0 whenever nib_out_valid = 0.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after DONE or ERR.

Test Plan:
- Word read at addr 0x000010, bk_rdata = 0xDEADBEEF.
  - Required: bk_rd with bk_addr = 4.
  - nib_out sequence F, E, E, B, D, A, E, D, with nib_pos 000, 100, 001, 101, 010, 110, 011, 111.
  - mem_ready 11 cycles after accept.
- Byte read at addr 0x000023, bk_rdata = 0x8A000000 -> nibbles A, 8 only; mem_ready 5 cycles after accept.
- Half write at addr 0x000006, nibbles 4, 3, 2, 1 with one idle gap after the second nibble.
  - Required: bk_wr with bk_addr = 1, bk_be = 1100, bk_wdata = 0x12340000, then mem_ready.
- Misaligned half at addr 0x000005, plus type 00 at addr 0 -> mem_err pulse each time; no bk_rd or bk_wr; back in IDLE next cycle.
- Reset asserted after 3 of 8 word-write nibbles -> outputs cleared at once, req_ready = 1, no bk_wr ever issued.
  - A following word read completes normally.
- ADDR_LIMIT = 24'h7F_FFFF with a read at 0x800000 -> mem_err.
  - A read at 0x7FFFFC with type word succeeds.
